// File: rtl/ram_port_sched.sv
// ram_port_sched: round-robin write arbiter and credit-limited read scheduler in front of a simple 2-port RAM.
// Optional macro RAM_PORT_SCHED_RAW_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram_port_sched #(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_req,
  output logic [NWR-1:0]        wr_gnt,
  input  logic [NWR*BDADDR-1:0] wr_addr,
  input  logic [NWR*BDWORD-1:0] wr_word,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic [BDADDR-1:0]     rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BDWORD-1:0]     rd_data,
  output logic                  ram_rd_en,
  output logic [BDADDR-1:0]     ram_rd_addr,
  input  logic [BDWORD-1:0]     ram_rd_word,
  output logic                  ram_wr_en,
  output logic [BDADDR-1:0]     ram_wr_addr,
  output logic [BDWORD-1:0]     ram_wr_word
);

  localparam int            PW    = $clog2(NWR);
  localparam logic [PW:0]   NWR_C = (PW+1)'(NWR);

  // ---------------------------------------------------------------------------
  // Write side: round-robin search starting at ptr
  // ---------------------------------------------------------------------------
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [PW:0]   cand;

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first; a path that skips one would infer a latch.
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Walk from the farthest candidate back to ptr so the closest requester wins.
    for (int k = NWR - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= NWR_C) cand = cand - NWR_C;
      if (wr_req[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    wr_gnt      = '0;
    ram_wr_addr = '0;
    ram_wr_word = '0;
    if (gnt_any && !rst) wr_gnt[gnt_idx] = 1'b1;
    for (int i = 0; i < NWR; i++) begin
      if (wr_gnt[i]) begin
        ram_wr_addr = wr_addr[i*BDADDR +: BDADDR];
        ram_wr_word = wr_word[i*BDWORD +: BDWORD];
      end
    end
  end

  assign ram_wr_en = |wr_gnt;

  // ---------------------------------------------------------------------------
  // Read side: one RAM stage (s1) plus a 2-entry return FIFO
  // ---------------------------------------------------------------------------
  logic              s1;
  logic [1:0]        cnt;
  logic              wr_sel;
  logic              rd_sel;
  logic [BDWORD-1:0] fifo_mem [2];
  logic [BDWORD-1:0] push_word;
  logic              push;
  logic              pop;
  logic              room;

  assign rd_valid    = (cnt != 2'd0);
  assign pop         = rd_valid & rd_ready;
  assign push        = s1;
  assign room        = (({1'b0, s1} + cnt) < 2'd2);
  assign rd_gnt      = ~rst & rd_req & (room | pop);
  assign ram_rd_en   = rd_gnt;
  assign ram_rd_addr = rd_addr;
  assign rd_data     = fifo_mem[rd_sel];

`ifdef RAM_PORT_SCHED_RAW_BYPASS_EN
  logic              hit_q;
  logic [BDWORD-1:0] byp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= rd_gnt & ram_wr_en & (rd_addr == ram_wr_addr);
      byp_q <= ram_wr_word;
    end
  end

  // The RAM returns the pre-write word on a collision; substitute the captured write data.
  assign push_word = hit_q ? byp_q : ram_rd_word;
`else
  assign push_word = ram_rd_word;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr    <= '0;
      s1     <= 1'b0;
      cnt    <= 2'd0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (gnt_any) ptr <= ({1'b0, gnt_idx} == NWR_C - 1'b1) ? '0 : gnt_idx + 1'b1;
      s1 <= rd_gnt;
      if (push) wr_sel <= ~wr_sel;
      if (pop)  rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; cnt gates rd_valid so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_sel] <= push_word;
  end

  a_one_write: assert property (@(posedge clk) disable iff (rst) $onehot0(wr_gnt));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cnt == 2'd2 && !pop));

endmodule

// File: doc/ram_port_sched.md
RAM_PORT_SCHED -- requirements
Module: ram_port_sched

Interface
REQ-001 SHALL have parameter BDADDR, default 12, RAM address width.
REQ-002 SHALL have parameter BDWORD, default 2048, RAM word width.
REQ-003 SHALL have parameter NWR, default 2, number of write requesters (2..8).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports wr_req / wr_gnt, input / output, NWR each, per-requester write request and grant.
REQ-007 SHALL have ports wr_addr / wr_word, input, NWR*BDADDR / NWR*BDWORD, packed per-requester write address and data; requester i occupies slice i.
REQ-008 SHALL have ports rd_req / rd_gnt, input / output, 1 each, read request and acceptance.
REQ-009 SHALL have port rd_addr, input, BDADDR, read address, sampled when rd_gnt=1.
REQ-010 SHALL have ports rd_valid / rd_ready / rd_data, output / input / output, 1 / 1 / BDWORD, read-return handshake.
REQ-011 SHALL have RAM-side ports ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_word as outputs and ram_rd_word as input, widths matching the simple 2-port RAM (read data 1 cycle after address; read returns pre-write data on a same-address collision).

Function
REQ-012 SHALL grant at most one write per cycle; wr_gnt is combinational from wr_req and the round-robin pointer.
REQ-013 SHALL search round-robin starting at pointer index; after a grant to i, pointer becomes (i+1) mod NWR; no grant leaves pointer unchanged.
REQ-014 SHALL drive ram_wr_en=|wr_gnt, ram_wr_addr/ram_wr_word from the granted slice, same cycle (zero latency).
REQ-015 SHALL drive ram_rd_en=rd_gnt and ram_rd_addr=rd_addr combinationally.
REQ-016 SHALL hold in-flight state: stage flag s1 (read issued last cycle) and a 2-entry return FIFO (count cnt 0..2).
REQ-017 SHALL assert rd_gnt=rd_req when (s1+cnt)<2 or a pop (rd_valid&rd_ready) occurs this cycle; otherwise rd_gnt=0.
REQ-018 SHALL push ram_rd_word into FIFO on every cycle with s1=1; FIFO never overflows under REQ-017.
REQ-019 SHALL present FIFO head on rd_data with rd_valid=(cnt!=0); accepted read returns earliest at cycle t+2, in issue order.
REQ-020 SHALL sustain one read per cycle with rd_ready held high, and one write per cycle concurrently.
REQ-021 SHALL keep rd_data stable while rd_valid=1 and rd_ready=0.
REQ-022 SHALL treat simultaneous push and pop as count-neutral.

Reset
REQ-023 SHALL on rst=1 clear pointer to 0, s1 to 0, cnt to 0; rd_valid=0 in the following cycle.
REQ-024 SHALL force wr_gnt=0, rd_gnt=0, ram_wr_en=0, ram_rd_en=0 while rst=1.
REQ-025 SHALL discard in-flight and buffered reads on reset mid-operation; RAM contents untouched.

Configuration
REQ-026 SHALL, with macro RAM_PORT_SCHED_RAW_BYPASS_EN defined, register a hit flag and write data when an accepted read and granted write share an address in the same cycle, and push the captured write data instead of ram_rd_word.
REQ-027 SHALL, without RAM_PORT_SCHED_RAW_BYPASS_EN, return the pre-write RAM word on such a collision; no compare logic present.

Verification
REQ-028 SHALL cover: wr_req=2'b11 held 4 cycles, pointer 0 -> grants 0,1,0,1.
REQ-029 SHALL cover: write 0x5A at addr 3, read addr 3 next cycle, rd_ready=1 -> rd_data=0x5A two cycles after rd_gnt.
REQ-030 SHALL cover: 3 back-to-back reads with rd_ready=0 -> rd_gnt high 2 cycles then 0; release ready -> 3 returns in order, no loss.
REQ-031 SHALL cover: same-cycle write 0xFF / read of addr 7 holding 0x11 -> 0xFF with bypass macro, 0x11 without.
REQ-032 SHALL cover: rst pulsed with cnt=2 and s1=1 -> rd_valid=0 next cycle, no stale return after reset release.
